// File: rtl/id_ex_stage.sv
// id_ex_stage: decode->execute pipeline register with bubble insertion and operand forwarding
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int ALUC_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallD,
  input  logic              flushE,
  input  logic              stallE,
  input  logic [DATA_W-1:0] rd1D,
  input  logic [DATA_W-1:0] rd2D,
  input  logic [DATA_W-1:0] immD,
  input  logic [DATA_W-1:0] pcplus4D,
  input  logic [4:0]        rsD,
  input  logic [4:0]        rtD,
  input  logic [4:0]        rdD,
  input  logic              regwriteD,
  input  logic              memtoregD,
  input  logic              memwriteD,
  input  logic              alusrcD,
  input  logic              regdstD,
  input  logic [ALUC_W-1:0] alucontrolD,
  input  logic [1:0]        forwardaE,
  input  logic [1:0]        forwardbE,
  input  logic [DATA_W-1:0] aluoutM,
  input  logic [DATA_W-1:0] resultW,
  output logic [4:0]        rsE,
  output logic [4:0]        rtE,
  output logic [4:0]        writeregE,
  output logic              regwriteE,
  output logic              memtoregE,
  output logic              memwriteE,
  output logic [ALUC_W-1:0] alucontrolE,
  output logic [DATA_W-1:0] srcaE,
  output logic [DATA_W-1:0] srcbE,
  output logic [DATA_W-1:0] writedataE,
  output logic [DATA_W-1:0] pcplus4E,
  output logic              validE,
  output logic [CNT_W-1:0]  bubble_cnt
);
  typedef struct packed {
    logic              regwrite;
    logic              memtoreg;
    logic              memwrite;
    logic              alusrc;
    logic              regdst;
    logic [ALUC_W-1:0] aluc;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc4;
    logic              valid;
  } e_t;
  e_t               e_q, e_d, load;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bubble;
  logic [DATA_W-1:0] fa, fb;
  // Next E contents: flush beats stallE beats stallD; a bubble is all-zero so hazard compares never match
  always_comb begin
    load   = '{regwriteD, memtoregD, memwriteD, alusrcD, regdstD, alucontrolD,
               rsD, rtD, rdD, rd1D, rd2D, immD, pcplus4D, 1'b1};
    bubble = flushE | (~stallE & stallD);
    e_d    = bubble ? '0 : stallE ? e_q : load;
    cnt_d  = (bubble && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  // E register and saturating bubble counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      cnt_q <= cnt_d;
    end
  end
  // Forwarding muxes; 11 falls back to the register value like 00
  always_comb begin
    fa = forwardaE == 2'b10 ? aluoutM : forwardaE == 2'b01 ? resultW : e_q.rd1;
    fb = forwardbE == 2'b10 ? aluoutM : forwardbE == 2'b01 ? resultW : e_q.rd2;
  end
  assign srcaE       = fa;
  assign writedataE  = fb;
  assign srcbE       = e_q.alusrc ? e_q.imm : fb;
  assign writeregE   = e_q.regdst ? e_q.rd : e_q.rt;
  assign rsE         = e_q.rs;
  assign rtE         = e_q.rt;
  assign regwriteE   = e_q.regwrite;
  assign memtoregE   = e_q.memtoreg;
  assign memwriteE   = e_q.memwrite;
  assign alucontrolE = e_q.aluc;
  assign pcplus4E    = e_q.pc4;
  assign validE      = e_q.valid;
  assign bubble_cnt  = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of capture, forwarding, bubbles and counter saturation
module tb_id_ex_stage;
  logic clk = 0, rst = 0;
  logic stallD = 0, flushE = 0, stallE = 0;
  logic [31:0] rd1D = 0, rd2D = 0, immD = 0, pcplus4D = 0, aluoutM = 0, resultW = 0;
  logic [4:0]  rsD = 0, rtD = 0, rdD = 0;
  logic regwriteD = 0, memtoregD = 0, memwriteD = 0, alusrcD = 0, regdstD = 0;
  logic [2:0]  alucontrolD = 0;
  logic [1:0]  forwardaE = 0, forwardbE = 0;
  logic [4:0]  rsE, rtE, writeregE, x_rsE, x_rtE, x_writeregE;
  logic regwriteE, memtoregE, memwriteE, validE, x_regwriteE, x_memtoregE, x_memwriteE, x_validE;
  logic [2:0]  alucontrolE, x_alucontrolE;
  logic [31:0] srcaE, srcbE, writedataE, pcplus4E, x_srcaE, x_srcbE, x_writedataE, x_pcplus4E;
  logic [15:0] bubble_cnt;
  logic [1:0]  x_bubble_cnt;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .stallD(stallD), .flushE(flushE), .stallE(stallE),
    .rd1D(rd1D), .rd2D(rd2D), .immD(immD), .pcplus4D(pcplus4D),
    .rsD(rsD), .rtD(rtD), .rdD(rdD), .regwriteD(regwriteD), .memtoregD(memtoregD),
    .memwriteD(memwriteD), .alusrcD(alusrcD), .regdstD(regdstD), .alucontrolD(alucontrolD),
    .forwardaE(forwardaE), .forwardbE(forwardbE), .aluoutM(aluoutM), .resultW(resultW),
    .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE), .memtoregE(memtoregE),
    .memwriteE(memwriteE), .alucontrolE(alucontrolE), .srcaE(srcaE), .srcbE(srcbE),
    .writedataE(writedataE), .pcplus4E(pcplus4E), .validE(validE), .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .stallD(stallD), .flushE(flushE), .stallE(stallE),
    .rd1D(rd1D), .rd2D(rd2D), .immD(immD), .pcplus4D(pcplus4D),
    .rsD(rsD), .rtD(rtD), .rdD(rdD), .regwriteD(regwriteD), .memtoregD(memtoregD),
    .memwriteD(memwriteD), .alusrcD(alusrcD), .regdstD(regdstD), .alucontrolD(alucontrolD),
    .forwardaE(forwardaE), .forwardbE(forwardbE), .aluoutM(aluoutM), .resultW(resultW),
    .rsE(x_rsE), .rtE(x_rtE), .writeregE(x_writeregE), .regwriteE(x_regwriteE),
    .memtoregE(x_memtoregE), .memwriteE(x_memwriteE), .alucontrolE(x_alucontrolE),
    .srcaE(x_srcaE), .srcbE(x_srcbE), .writedataE(x_writedataE), .pcplus4E(x_pcplus4E),
    .validE(x_validE), .bubble_cnt(x_bubble_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1;
    rd1D = 32'h11; rd2D = 32'h22; pcplus4D = 32'h104; rtD = 5'd3;
    #1;
    checks++; if (validE !== 1'b0) begin errors++; $display("FAIL reset_valid got %h exp 0", validE); end
    checks++; if (srcaE !== 32'h0) begin errors++; $display("FAIL reset_srca got %h exp 0", srcaE); end
    checks++; if (writedataE !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", writedataE); end
    checks++; if (rtE !== 5'd0 || writeregE !== 5'd0) begin errors++; $display("FAIL reset_regs got rt %h wr %h exp 0", rtE, writeregE); end
    checks++; if (bubble_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", bubble_cnt); end
    @(negedge clk) rst = 0;
    tick();
    checks++; if (srcaE !== 32'h11) begin errors++; $display("FAIL load_srca got %h exp 11", srcaE); end
    checks++; if (writedataE !== 32'h22) begin errors++; $display("FAIL load_wdata got %h exp 22", writedataE); end
    checks++; if (validE !== 1'b1) begin errors++; $display("FAIL load_valid got %h exp 1", validE); end
    checks++; if (pcplus4E !== 32'h104 || rtE !== 5'd3) begin errors++; $display("FAIL load_fields got pc %h rt %h exp 104 3", pcplus4E, rtE); end
  endtask

  task automatic test_forward();
    rd1D = 32'd5; rd2D = 32'd6;
    tick();
    forwardaE = 2'b10; aluoutM = 32'hDEAD; resultW = 32'hBEEF;
    #1;
    checks++; if (srcaE !== 32'hDEAD) begin errors++; $display("FAIL fwd_a_mem got %h exp dead", srcaE); end
    forwardaE = 2'b01; #1;
    checks++; if (srcaE !== 32'hBEEF) begin errors++; $display("FAIL fwd_a_wb got %h exp beef", srcaE); end
    forwardaE = 2'b11; #1;
    checks++; if (srcaE !== 32'd5) begin errors++; $display("FAIL fwd_a_11 got %h exp 5", srcaE); end
    forwardaE = 2'b00; forwardbE = 2'b10; #1;
    checks++; if (srcaE !== 32'd5) begin errors++; $display("FAIL fwd_a_00 got %h exp 5", srcaE); end
    checks++; if (writedataE !== 32'hDEAD || srcbE !== 32'hDEAD) begin errors++; $display("FAIL fwd_b_mem got wd %h sb %h exp dead", writedataE, srcbE); end
    forwardbE = 2'b01; #1;
    checks++; if (srcbE !== 32'hBEEF) begin errors++; $display("FAIL fwd_b_wb got %h exp beef", srcbE); end
    forwardbE = 2'b00; #1;
    checks++; if (srcbE !== 32'd6) begin errors++; $display("FAIL fwd_b_00 got %h exp 6", srcbE); end
  endtask

  task automatic test_alusrc();
    alusrcD = 1; immD = 32'hFFFFFFFC; rd2D = 32'd7; regdstD = 1; rdD = 5'd9; rtD = 5'd4;
    tick();
    checks++; if (srcbE !== 32'hFFFFFFFC) begin errors++; $display("FAIL alusrc_srcb got %h exp fffffffc", srcbE); end
    checks++; if (writedataE !== 32'd7) begin errors++; $display("FAIL alusrc_wdata got %h exp 7", writedataE); end
    checks++; if (writeregE !== 5'd9) begin errors++; $display("FAIL wreg_rd got %0d exp 9", writeregE); end
    alusrcD = 0; regdstD = 0;
    tick();
    checks++; if (writeregE !== 5'd4) begin errors++; $display("FAIL wreg_rt got %0d exp 4", writeregE); end
    checks++; if (srcbE !== 32'd7) begin errors++; $display("FAIL noalusrc_srcb got %h exp 7", srcbE); end
  endtask

  task automatic test_stall_d();
    regwriteD = 1; memtoregD = 1; rtD = 5'd8; stallD = 1;
    tick();
    stallD = 0;
    checks++; if (validE !== 1'b0 || regwriteE !== 1'b0 || memtoregE !== 1'b0) begin errors++; $display("FAIL stallD_ctrl got v %b rw %b mr %b exp 0", validE, regwriteE, memtoregE); end
    checks++; if (rtE !== 5'd0 || writeregE !== 5'd0 || srcaE !== 32'd0) begin errors++; $display("FAIL stallD_zero got rt %0d wr %0d sa %h exp 0", rtE, writeregE, srcaE); end
    checks++; if (bubble_cnt !== 16'd1) begin errors++; $display("FAIL stallD_cnt got %0d exp 1", bubble_cnt); end
  endtask

  task automatic test_stall_e();
    rd1D = 32'h77; rtD = 5'd8;
    tick();
    checks++; if (validE !== 1'b1 || rtE !== 5'd8 || regwriteE !== 1'b1) begin errors++; $display("FAIL reload got v %b rt %0d rw %b exp 1 8 1", validE, rtE, regwriteE); end
    stallE = 1; stallD = 1; rd1D = 32'h99; rtD = 5'd2;
    tick();
    checks++; if (validE !== 1'b1 || rtE !== 5'd8 || srcaE !== 32'h77) begin errors++; $display("FAIL stallE_hold got v %b rt %0d sa %h exp 1 8 77", validE, rtE, srcaE); end
    checks++; if (bubble_cnt !== 16'd1) begin errors++; $display("FAIL stallE_cnt got %0d exp 1", bubble_cnt); end
    flushE = 1;
    tick();
    flushE = 0; stallE = 0;
    checks++; if (validE !== 1'b0 || rtE !== 5'd0 || srcaE !== 32'd0) begin errors++; $display("FAIL flush_bubble got v %b rt %0d sa %h exp 0", validE, rtE, srcaE); end
    checks++; if (bubble_cnt !== 16'd2) begin errors++; $display("FAIL flush_cnt got %0d exp 2", bubble_cnt); end
  endtask

  task automatic test_saturate();
    stallD = 1;
    repeat (5) tick();
    checks++; if (x_bubble_cnt !== 2'd3) begin errors++; $display("FAIL sat_cnt2 got %0d exp 3", x_bubble_cnt); end
    checks++; if (bubble_cnt !== 16'd7) begin errors++; $display("FAIL sat_cnt16 got %0d exp 7", bubble_cnt); end
    #2 rst = 1;
    #1;
    checks++; if (x_bubble_cnt !== 2'd0 || bubble_cnt !== 16'd0) begin errors++; $display("FAIL async_rst_cnt got %0d %0d exp 0", x_bubble_cnt, bubble_cnt); end
    @(negedge clk) rst = 0; stallD = 0; rd1D = 32'h55;
    tick();
    checks++; if (validE !== 1'b1 || srcaE !== 32'h55 || x_validE !== 1'b1) begin errors++; $display("FAIL post_rst_load got v %b sa %h exp 1 55", validE, srcaE); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_alusrc();
    test_stall_d();
    test_stall_e();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end
endmodule
